sram_axi_reader: RTL
====================

# sram_axi_reader

Sequential-read AXI-lite master that sits directly upstream of `sram_axi` on its read-address/read-data channels. It accepts a command (start address, word count) and issues consecutive single-word AR requests, keeping several in flight. Returned words are buffered in a FIFO and presented to a consumer (scan-out, DMA, checksum) as a valid/ready stream with a last marker. Credit-based issue guarantees every outstanding response has a FIFO slot, so `r_ready` never back-pressures `sram_axi`.

## Interface
- `ADDR_W`, 18, word address width (matches `sram_axi`)
- `DATA_W`, 16, data width
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥ 2
- `MAX_OUTST`, 4, max AR accepted without R returned; 1 ≤ MAX_OUTST ≤ FIFO_DEPTH
- One clock; reset is synchronous and active-high.
- `a_clk` in 1 — clock
- `a_rst` in 1 — synchronous active-high reset
- `cmd_valid` in 1, `cmd_ready` out 1 — command handshake
- `cmd_addr` in ADDR_W — first word address
- `cmd_len` in ADDR_W — word count; 0 = no-op
- `ar_valid` out 1, `ar_ready` in 1, `ar_addr` out ADDR_W, `ar_prot` out 1 (constant 0)
- `r_valid` in 1, `r_ready` out 1, `r_data` in DATA_W, `r_resp` in 1 (1 = error)
- `o_valid` out 1, `o_ready` in 1, `o_data` out DATA_W, `o_last` out 1 — output stream
- `busy` out 1 — command in progress
- `err` out 1 — sticky error for current/last command

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: `cmd_ready`=1. Accept on `cmd_valid`: latch addr, `to_issue`=`to_recv`=`cmd_len`, clear `err`. len≠0 → ISSUE; len=0 → stay IDLE, nothing issued, no stream output.
- ISSUE: `ar_valid` when `to_issue`>0 ∧ `outst`<MAX_OUTST ∧ `fifo_count`+`outst`<FIFO_DEPTH. Once asserted, `ar_valid` and `ar_addr` hold until `ar_ready`. Each AR handshake: `ar_addr`+1 (wraps modulo 2^ADDR_W), `to_issue`−1, `outst`+1. The last AR handshake → WAIT.
- WAIT: no AR. Leave for IDLE in the cycle the word with `o_last` is popped (`o_valid`∧`o_ready`∧`o_last`).
- `r_ready`=1 at all times. R handshake while `outst`>0: push `{r_data, to_recv==1}` into FIFO, `outst`−1, `to_recv`−1; `r_resp`=1 sets `err` and the data is still forwarded. R handshake with `outst`=0 (stale, e.g. after reset): discarded, no counter or `err` change.
- Same-cycle AR and R: `outst` unchanged. Same-cycle push and pop: `fifo_count` unchanged. Credit rule ⇒ push into full FIFO impossible; overflow is an assertion failure.
- `busy` = state≠IDLE. `err` holds after return to IDLE until the next command accept.

## Timing
- Reset values: `cmd_ready`=1 (after reset cycle), `ar_valid`=0, `ar_addr`=0, `ar_prot`=0, `r_ready`=1, `o_valid`=0, `o_data`=0, `o_last`=0, `busy`=0, `err`=0; FIFO empty, counters 0.
- Cmd accept at edge T → `ar_valid`=1 in cycle T+1 with `ar_addr`=`cmd_addr`.
- R handshake at edge R → `o_valid`=1 from cycle R+1 (registered FIFO, no bypass).
- With `ar_ready`=1 and `sram_axi` pipelined: one AR per cycle sustained while credit permits.
- Reset mid-command: everything returns to reset values on the next edge; in-flight R beats are absorbed as stale.
- Final pop at edge L → `busy`=0, `cmd_ready`=1 in cycle L+1.

## Structure
- `sram_axi_pkg`: `ADDR_W`, `DATA_W`, state enum `rd_state_t` {IDLE, ISSUE, WAIT}; shared with `sram_axi`.
- Sub-module `sram_stream_fifo`: synchronous FIFO, width DATA_W+1, depth FIFO_DEPTH, `count` output, registered read data.
- Counters `outst` ($clog2(MAX_OUTST+1) bits), `to_issue`/`to_recv` (ADDR_W bits).

## Test plan
- Bench uses `sram_axi`+`sram_top`+the data=address SRAM model. Cmd addr=0x10, len=4, `o_ready`=1 → `o_data` 0x0010..0x0013 in order, `o_last` only on 0x0013, `busy` drops one cycle after the last pop.
- len=20, `o_ready`=0 for 30 cycles, then 1 → exactly FIFO_DEPTH ARs issued while stalled, `r_ready` never low, no overflow; all 20 words delivered in order.
- addr=0x3FFFE, len=4 → `ar_addr` 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; `o_data` 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Direct AXI responder with `ar_ready` low for 3 cycles per beat → `ar_valid`/`ar_addr` stable while waiting; `outst` never exceeds MAX_OUTST=4.
- Responder returns `r_resp`=1 on the 2nd of 3 beats → all 3 words delivered, `err`=1 after the command, cleared on next accept.
- Reset asserted with 3 reads outstanding, responder returns 3 beats afterwards → `o_valid` stays 0, `err`=0; next cmd len=2 completes normally; cmd len=0 leaves `busy`=0 and issues no AR.

Source files
------------

// File: rtl/sram_axi_pkg.sv
// ---------------------------------------------------------------------------
// sram_axi_pkg: widths and read-master state type shared with sram_axi.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_axi_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_stream_fifo.sv
// ---------------------------------------------------------------------------
// sram_stream_fifo: synchronous FIFO with occupancy count and registered storage.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_stream_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_i && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!push_i && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Upstream credit accounting must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && (count_q == CNT_W'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/sram_axi_reader.sv
// ---------------------------------------------------------------------------
// sram_axi_reader: credit-based sequential AXI-lite read master with stream output.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_axi_reader #(
  parameter int ADDR_W     = sram_axi_pkg::ADDR_W,
  parameter int DATA_W     = sram_axi_pkg::DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_OUTST  = 4
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic              ar_prot,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_resp,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              busy,
  output logic              err
);

  import sram_axi_pkg::*;

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [ADDR_W-1:0] to_issue_q, to_issue_d;
  logic [ADDR_W-1:0] to_recv_q, to_recv_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic              ar_valid_q, ar_valid_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W:0]   fifo_rd;
  logic              push, pop, ar_hs, fifo_valid;

  assign ar_hs      = ar_valid_q && ar_ready;
  // Beats arriving with nothing outstanding are stale (e.g. issued before a reset).
  assign push       = r_valid && (outst_q != '0);
  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && o_ready;

  sram_stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (a_clk),
    .rst_i   (a_rst),
    .push_i  (push),
    .data_i  ({r_data, (to_recv_q == ADDR_W'(1))}),
    .pop_i   (pop),
    .data_o  (fifo_rd),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    ar_addr_d  = ar_addr_q;
    to_issue_d = to_issue_q;
    to_recv_d  = to_recv_q;
    outst_d    = outst_q;
    err_d      = err_q;
    ar_valid_d = 1'b0;

    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + CNT_W'(1);
    else if (!push && pop) count_d = fifo_count - CNT_W'(1);

    if (state_q == IDLE) begin
      if (cmd_valid) begin
        ar_addr_d  = cmd_addr;
        to_issue_d = cmd_len;
        to_recv_d  = cmd_len;
        err_d      = 1'b0;
        if (cmd_len != '0) begin
          state_d    = ISSUE;
          ar_valid_d = 1'b1;
        end
      end
    end else begin
      if (ar_hs) begin
        ar_addr_d  = ar_addr_q + ADDR_W'(1);
        to_issue_d = to_issue_q - ADDR_W'(1);
      end
      if (push) begin
        to_recv_d = to_recv_q - ADDR_W'(1);
        if (r_resp) err_d = 1'b1;
      end
      case ({ar_hs, push})
        2'b10:   outst_d = outst_q + OUT_W'(1);
        2'b01:   outst_d = outst_q - OUT_W'(1);
        default: outst_d = outst_q;
      endcase

      if (state_q == ISSUE) begin
        if (ar_hs && (to_issue_q == ADDR_W'(1))) state_d = WAIT;
        // Credit check on next-cycle values keeps ar_valid registered yet one AR per cycle.
        if (ar_valid_q && !ar_ready) begin
          ar_valid_d = 1'b1;
        end else if ((to_issue_d != '0) && (int'(outst_d) < MAX_OUTST) &&
                     (int'(count_d) + int'(outst_d) < FIFO_DEPTH)) begin
          ar_valid_d = 1'b1;
        end
      end

      if (pop && fifo_rd[0]) state_d = IDLE;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q    <= IDLE;
      ar_addr_q  <= '0;
      to_issue_q <= '0;
      to_recv_q  <= '0;
      outst_q    <= '0;
      ar_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_addr_q  <= ar_addr_d;
      to_issue_q <= to_issue_d;
      to_recv_q  <= to_recv_d;
      outst_q    <= outst_d;
      ar_valid_q <= ar_valid_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ar_valid  = ar_valid_q;
  assign ar_addr   = ar_addr_q;
  assign ar_prot   = 1'b0;
  assign r_ready   = 1'b1;
  assign o_valid   = fifo_valid;
  assign o_data    = fifo_rd[DATA_W:1];
  assign o_last    = fifo_rd[0];
  assign err       = err_q;

endmodule

`default_nettype wire
